// File: rtl/inst_mem_sync_if.sv
// Fetch/response/program-load bundle between the fetch stage and the instruction memory.
// master = fetch/loader side, slave = memory side.
interface inst_mem_sync_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [1:0]        rsp_fault;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_err;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault, ld_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_instr, rsp_fault, ld_err
    );
endinterface

// File: rtl/inst_mem_sync.sv
// Instruction memory with one-cycle registered fetch response, held under back-pressure,
// plus a program-load write port with alignment/range checking on both ports.
module inst_mem_sync #(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 64,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_mem_sync_if.slave    bus
);
    localparam int OFS  = $clog2(DATA_W / 8);
    localparam int WI_W = ADDR_W - OFS;
    localparam int MI_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WI_W:0] DEPTH_L = (WI_W + 1)'(DEPTH);

    // Bit 0: misaligned, bit 1: word index beyond the array.
    function automatic logic [1:0] addr_fault(input logic [ADDR_W-1:0] addr);
        logic [WI_W:0] widx;
        widx = {1'b0, addr[ADDR_W-1:OFS]};
        return {(widx >= DEPTH_L), (addr[OFS-1:0] != {OFS{1'b0}})};
    endfunction

    function automatic logic [MI_W-1:0] mem_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFS +: MI_W];
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_instr_r;
    logic [1:0]        rsp_fault_r;
    logic              ld_err_r;

    logic              req_ready_s;
    logic              accept_s;
    logic [1:0]        req_fault_s;
    logic [1:0]        ld_fault_s;
    logic              ld_ok_s;
    logic [DATA_W-1:0] rd_word_s;

    // Handshake, fault classification and read-data selection.
    always_comb begin
        req_ready_s = 1'b0;
        accept_s    = 1'b0;
        req_fault_s = 2'b00;
        ld_fault_s  = 2'b00;
        ld_ok_s     = 1'b0;
        rd_word_s   = NOP;

        req_ready_s = !rsp_valid_r || bus.rsp_ready;
        accept_s    = bus.req_valid && req_ready_s;
        req_fault_s = addr_fault(bus.req_addr);
        ld_fault_s  = addr_fault(bus.ld_addr);
        ld_ok_s     = bus.ld_en && (ld_fault_s == 2'b00);
        if (req_fault_s == 2'b00) begin
            rd_word_s = mem_r[mem_idx(bus.req_addr)];
        end else begin
            rd_word_s = NOP;
        end
    end

    // Response register: loads on accept, empties when taken without a new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_instr_r <= {DATA_W{1'b0}};
            rsp_fault_r <= 2'b00;
            ld_err_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                rsp_valid_r <= 1'b1;
                rsp_instr_r <= rd_word_s;
                rsp_fault_r <= req_fault_s;
            end else if (bus.rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
            ld_err_r <= bus.ld_en && !ld_ok_s;
        end
    end

    // Array write; the read above sees the pre-edge word, giving read-before-write.
    always_ff @(posedge clk) begin
        if (ld_ok_s) begin
            mem_r[mem_idx(bus.ld_addr)] <= bus.ld_data;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_instr = rsp_instr_r;
    assign bus.rsp_fault = rsp_fault_r;
    assign bus.ld_err    = ld_err_r;
endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed and randomized bench for inst_mem_sync (DEPTH=32 build so range faults are reachable).
module tb_inst_mem_sync;
    localparam int          WORDS = 32;
    localparam logic [31:0] NOP_W = 32'h00000013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_mem_sync_if #(.ADDR_W(8), .DATA_W(32)) ifc ();

    inst_mem_sync #(.ADDR_W(8), .DATA_W(32), .DEPTH(WORDS), .NOP(32'h00000013)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    logic [31:0] mdl_mem [WORDS];
    bit          exp_valid  = 1'b0;
    logic [31:0] exp_instr  = 32'h0;
    logic [1:0]  exp_fault  = 2'b00;
    bit          exp_ld_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fault classification straight from the address rules.
    function automatic logic [1:0] fault_of(input int a);
        return {(a / 4) >= WORDS, (a % 4) != 0};
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic step(input bit rv, input int ra, input bit rr,
                        input bit le, input int la, input logic [31:0] ldat);
        bit acc;
        ifc.req_valid = rv;
        ifc.req_addr  = 8'(ra);
        ifc.rsp_ready = rr;
        ifc.ld_en     = le;
        ifc.ld_addr   = 8'(la);
        ifc.ld_data   = ldat;
        @(negedge clk);
        chk("rsp_valid", 32'(ifc.rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("rsp_instr", ifc.rsp_instr, exp_instr);
            chk("rsp_fault", 32'(ifc.rsp_fault), 32'(exp_fault));
        end
        chk("req_ready", 32'(ifc.req_ready), 32'(!exp_valid || rr));
        chk("ld_err", 32'(ifc.ld_err), 32'(exp_ld_err));
        acc = rv && (!exp_valid || rr);
        if (acc) begin
            exp_valid = 1'b1;
            exp_fault = fault_of(ra);
            exp_instr = (exp_fault != 2'b00) ? NOP_W : mdl_mem[ra / 4];
        end else if (rr) begin
            exp_valid = 1'b0;
        end
        exp_ld_err = le && (fault_of(la) != 2'b00);
        if (le && !exp_ld_err) mdl_mem[la / 4] = ldat;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b1, 1'b0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] prog [4];
        int ra;
        int la;
        prog[0] = 32'h00100093;
        prog[1] = 32'h00200113;
        prog[2] = 32'h00308193;
        prog[3] = 32'h00408213;

        ifc.req_valid = 1'b0;
        ifc.req_addr  = 8'h00;
        ifc.rsp_ready = 1'b0;
        ifc.ld_en     = 1'b0;
        ifc.ld_addr   = 8'h00;
        ifc.ld_data   = 32'h0;

        #12;
        chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'h0);
        chk("rst_rsp_instr", ifc.rsp_instr, 32'h0);
        chk("rst_rsp_fault", 32'(ifc.rsp_fault), 32'h0);
        chk("rst_ld_err", 32'(ifc.ld_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Program load then back-to-back fetches.
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b1, i * 4, prog[i]);
        step(1'b1, 0, 1'b1, 1'b0, 0, 32'h0);
        chk("t1_first", ifc.rsp_instr, 32'h00100093);
        for (int i = 1; i < 4; i++) step(1'b1, i * 4, 1'b1, 1'b0, 0, 32'h0);
        chk("t1_last", ifc.rsp_instr, 32'h00408213);
        idle();

        // Back-pressure hold.
        step(1'b1, 4, 1'b0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 8, 1'b0, 1'b0, 0, 32'h0);
        chk("t2_held", ifc.rsp_instr, 32'h00200113);
        step(1'b0, 0, 1'b1, 1'b0, 0, 32'h0);
        idle();

        // Fault responses.
        step(1'b1, 8'h06, 1'b1, 1'b0, 0, 32'h0);
        chk("t3_mis_instr", ifc.rsp_instr, NOP_W);
        chk("t3_mis_fault", 32'(ifc.rsp_fault), 32'h1);
        step(1'b1, 8'h80, 1'b1, 1'b0, 0, 32'h0);
        chk("t3_rng_fault", 32'(ifc.rsp_fault), 32'h2);
        step(1'b1, 8'h83, 1'b1, 1'b0, 0, 32'h0);
        chk("t3_both_fault", 32'(ifc.rsp_fault), 32'h3);
        idle();

        // Read-before-write on the same word.
        step(1'b1, 8, 1'b1, 1'b1, 8, 32'hDEADBEEF);
        chk("t4_old", ifc.rsp_instr, 32'h00308193);
        step(1'b1, 8, 1'b1, 1'b0, 0, 32'h0);
        chk("t4_new", ifc.rsp_instr, 32'hDEADBEEF);
        idle();

        // Dropped misaligned load.
        step(1'b0, 0, 1'b1, 1'b1, 8'h03, 32'hBAD0BAD0);
        chk("t5_err_pulse", 32'(ifc.ld_err), 32'h1);
        step(1'b1, 0, 1'b1, 1'b0, 0, 32'h0);
        chk("t5_err_clear", 32'(ifc.ld_err), 32'h0);
        chk("t5_word0", ifc.rsp_instr, 32'h00100093);
        idle();

        // Fill the rest, then random traffic (word 0 is left untouched).
        for (int w = 4; w < WORDS; w++) step(1'b0, 0, 1'b1, 1'b1, w * 4, $urandom);
        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 40)) * 4;
            la = int'($urandom_range(4, 255));
            step(1'(($urandom_range(0, 3) != 0)), ra, 1'(($urandom_range(0, 2) != 0)),
                 1'(($urandom_range(0, 3) == 0)), la, $urandom);
        end
        idle();

        // Async reset during a stalled response; memory persists.
        step(1'b1, 4, 1'b0, 1'b0, 0, 32'h0);
        chk("t6_stalled", 32'(ifc.rsp_valid), 32'h1);
        ifc.req_valid = 1'b0;
        ifc.ld_en     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(ifc.rsp_valid), 32'h0);
        chk("t6_rst_instr", ifc.rsp_instr, 32'h0);
        chk("t6_rst_fault", 32'(ifc.rsp_fault), 32'h0);
        exp_valid  = 1'b0;
        exp_ld_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 0, 1'b1, 1'b0, 0, 32'h0);
        chk("t6_persist", ifc.rsp_instr, 32'h00100093);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
